// File: rtl/dmem_responder.sv
// dmem_responder: multi-cycle data-memory responder for the MEM stage.
// Holds the pipeline with stall while an access is in flight. Supports
// byte/half/word loads and stores, with sign or zero extension on loads.
// Optional error counter output enabled by defining DMEM_ERRCNT_EN.
module dmem_responder #(
  parameter int unsigned DEPTHWORDS = 256,
  parameter int unsigned LATENCY    = 2
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        memread,
  input  logic        memwrite,
  input  logic [31:0] addr,
  input  logic [31:0] writedata,
  input  logic [1:0]  size,
  input  logic        unsignedload,
  output logic [31:0] memreadout,
  output logic        stall,
  output logic        done,
  output logic        misalign
`ifdef DMEM_ERRCNT_EN
  ,
  output logic [7:0]  errcount
`endif
);

  localparam int unsigned IDXW = $clog2(DEPTHWORDS);
  localparam int unsigned AW   = IDXW + 2;
  localparam int unsigned CNTW = 4;

  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_e;

  state_e            state_q, state_d;
  logic [CNTW-1:0]   cnt_q, cnt_d;
  logic [AW-1:0]     addr_q, addr_d;
  logic [31:0]       wdata_q, wdata_d;
  logic [1:0]        size_q, size_d;
  logic              uns_q, uns_d;
  logic              write_q, write_d;
  logic [31:0]       memreadout_q, memreadout_d;
  logic              done_q, done_d;
  logic              misalign_q, misalign_d;

  logic [31:0]       mem [DEPTHWORDS];
  logic [IDXW-1:0]   idx;
  logic [31:0]       rd_word;
  logic [31:0]       lane_sh;
  logic [31:0]       ld_val;
  logic [3:0]        be;
  logic [31:0]       lane_data;
  logic [31:0]       mem_wdata;
  logic              mem_we;
  logic              req_c;
  logic              err_c;
  logic              mis_c;
  logic              unused_addr_hi;

  assign unused_addr_hi = ^addr[31:AW];

  assign req_c = memread ^ memwrite;
  assign err_c = memread & memwrite;
  assign mis_c = ((size == 2'b01) && addr[0]) || (size[1] && (addr[1:0] != 2'b00));

  assign idx     = addr_q[AW-1:2];
  assign rd_word = mem[idx];

  // Load lane extraction/extension and store byte-merge from latched request
  always_comb begin
    lane_sh   = rd_word >> {addr_q[1:0], 3'b000};
    ld_val    = rd_word;
    be        = 4'b1111;
    lane_data = wdata_q;
    case (size_q)
      2'b00: begin
        ld_val    = uns_q ? {24'h0, lane_sh[7:0]} : {{24{lane_sh[7]}}, lane_sh[7:0]};
        be        = 4'b0001 << addr_q[1:0];
        lane_data = {4{wdata_q[7:0]}};
      end
      2'b01: begin
        ld_val    = uns_q ? {16'h0, lane_sh[15:0]} : {{16{lane_sh[15]}}, lane_sh[15:0]};
        be        = addr_q[1] ? 4'b1100 : 4'b0011;
        lane_data = {2{wdata_q[15:0]}};
      end
      default: begin
        ld_val    = rd_word;
        be        = 4'b1111;
        lane_data = wdata_q;
      end
    endcase
    for (int i = 0; i < 4; i++) begin
      mem_wdata[8*i +: 8] = be[i] ? lane_data[8*i +: 8] : rd_word[8*i +: 8];
    end
  end

  // Next-state, latching and output logic
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    size_d       = size_q;
    uns_d        = uns_q;
    write_d      = write_q;
    memreadout_d = memreadout_q;
    done_d       = 1'b0;
    misalign_d   = 1'b0;
    mem_we       = 1'b0;
    stall        = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (err_c || (req_c && mis_c)) begin
          // Rejected access: no array traffic, report straight away
          stall        = 1'b1;
          state_d      = S_DONE;
          done_d       = 1'b1;
          misalign_d   = 1'b1;
          memreadout_d = 32'h0;
        end else if (req_c) begin
          stall   = 1'b1;
          addr_d  = addr[AW-1:0];
          wdata_d = writedata;
          size_d  = size;
          uns_d   = unsignedload;
          write_d = memwrite;
          cnt_d   = CNTW'(LATENCY);
          state_d = S_BUSY;
        end
      end
      S_BUSY: begin
        stall = 1'b1;
        cnt_d = cnt_q - CNTW'(1);
        if (cnt_q == CNTW'(1)) begin
          state_d = S_DONE;
          done_d  = 1'b1;
          if (write_q) begin
            mem_we = 1'b1;
          end else begin
            memreadout_d = ld_val;
          end
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Control and output registers
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q      <= S_IDLE;
      cnt_q        <= '0;
      addr_q       <= '0;
      wdata_q      <= '0;
      size_q       <= '0;
      uns_q        <= 1'b0;
      write_q      <= 1'b0;
      memreadout_q <= '0;
      done_q       <= 1'b0;
      misalign_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      size_q       <= size_d;
      uns_q        <= uns_d;
      write_q      <= write_d;
      memreadout_q <= memreadout_d;
      done_q       <= done_d;
      misalign_q   <= misalign_d;
    end
  end

  // Storage array; not cleared by reset
  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem[idx] <= mem_wdata;
    end
  end

  assign memreadout = memreadout_q;
  assign done       = done_q;
  assign misalign   = misalign_q;

`ifdef DMEM_ERRCNT_EN
  logic [7:0] errcount_q, errcount_d;

  // Saturating count of rejected accesses, one per flagged DONE cycle
  always_comb begin
    errcount_d = errcount_q;
    if ((state_q == S_DONE) && misalign_q && (errcount_q != 8'hFF)) begin
      errcount_d = errcount_q + 8'd1;
    end
  end

  // Error counter register
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      errcount_q <= '0;
    end else begin
      errcount_q <= errcount_d;
    end
  end

  assign errcount = errcount_q;
`endif

endmodule

// File: tb/tb_dmem_responder.sv
// Scoreboard bench for dmem_responder: driver pushes expected responses,
// a monitor pops and compares on every done pulse.
module tb_dmem_responder;

  logic        clk;
  logic        rstn;
  logic        memread;
  logic        memwrite;
  logic [31:0] addr;
  logic [31:0] writedata;
  logic [1:0]  size;
  logic        unsignedload;
  logic [31:0] memreadout;
  logic        stall;
  logic        done;
  logic        misalign;
`ifdef DMEM_ERRCNT_EN
  logic [7:0]  errcount;
`endif

  dmem_responder #(.DEPTHWORDS(256), .LATENCY(2)) dut (
    .clk          (clk),
    .rstn         (rstn),
    .memread      (memread),
    .memwrite     (memwrite),
    .addr         (addr),
    .writedata    (writedata),
    .size         (size),
    .unsignedload (unsignedload),
    .memreadout   (memreadout),
    .stall        (stall),
    .done         (done),
    .misalign     (misalign)
`ifdef DMEM_ERRCNT_EN
    ,
    .errcount     (errcount)
`endif
  );

  typedef struct packed {
    logic [31:0] out;
    logic        mis;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  int   mis_events = 0;
  logic [31:0] last_read = 32'h0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: every done pulse must match the oldest expected response
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (done === 1'b1) begin
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_done: got done=1 expected no pending access at %0t", $time);
        end else begin
          exp_t e;
          e = sb.pop_front();
          chk("memreadout", memreadout, e.out);
          chk("misalign", 32'(misalign), 32'(e.mis));
        end
      end
    end
  end

  // One complete access; exp_stall < 0 skips the stall-length check
  task automatic access(input logic rd, input logic wr, input logic [31:0] a,
                        input logic [31:0] d, input logic [1:0] sz, input logic uns,
                        input logic [31:0] exp_out, input logic exp_mis,
                        input int exp_stall);
    int st;
    int guard;
    exp_t e;
    e.out = exp_out;
    e.mis = exp_mis;
    sb.push_back(e);
    if (exp_mis) mis_events++;
    @(negedge clk);
    memread = rd; memwrite = wr; addr = a; writedata = d; size = sz; unsignedload = uns;
    st = 0;
    guard = 0;
    #1;
    if (stall) st++;
    @(posedge clk);
    #1;
    memread = 1'b0; memwrite = 1'b0;
    @(negedge clk);
    while (stall && guard < 40) begin
      st++;
      guard++;
      @(negedge clk);
    end
    if (guard >= 40) begin
      checks++;
      errors++;
      $display("FAIL stall_timeout: got stall stuck high expected release at %0t", $time);
    end
    if (exp_stall >= 0) chk("stall_cycles", 32'(st), 32'(exp_stall));
    if (sb.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL missing_done: got %0d pending expected 0 at %0t", sb.size(), $time);
      sb.delete();
    end
    last_read = exp_out;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rstn = 1'b0; memread = 1'b0; memwrite = 1'b0; addr = '0;
    writedata = '0; size = 2'b10; unsignedload = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_memreadout", memreadout, 32'h0);
    chk("rst_stall", 32'(stall), 32'h0);
    chk("rst_done", 32'(done), 32'h0);
    chk("rst_misalign", 32'(misalign), 32'h0);
    rstn = 1'b1;
    @(negedge clk);

    // Word store then load
    access(0, 1, 32'h10, 32'hDEADBEEF, 2'b10, 0, 32'h0,        0, 3);
    access(1, 0, 32'h10, 32'h0,        2'b10, 0, 32'hDEADBEEF, 0, 3);
    // Byte lanes
    access(0, 1, 32'h20, 32'h11223344, 2'b10, 0, last_read,    0, 3);
    access(0, 1, 32'h22, 32'h123456AA, 2'b00, 0, last_read,    0, 3);
    access(1, 0, 32'h20, 32'h0,        2'b10, 0, 32'h11AA3344, 0, 3);
    access(1, 0, 32'h22, 32'h0,        2'b00, 0, 32'hFFFFFFAA, 0, 3);
    access(1, 0, 32'h22, 32'h0,        2'b00, 1, 32'h000000AA, 0, 3);
    access(1, 0, 32'h21, 32'h0,        2'b00, 0, 32'h00000033, 0, 3);
    // Halfword sign/zero extension and half store
    access(0, 1, 32'h30, 32'h80017FFF, 2'b10, 0, last_read,    0, 3);
    access(1, 0, 32'h32, 32'h0,        2'b01, 0, 32'hFFFF8001, 0, 3);
    access(1, 0, 32'h30, 32'h0,        2'b01, 0, 32'h00007FFF, 0, 3);
    access(1, 0, 32'h32, 32'h0,        2'b01, 1, 32'h00008001, 0, 3);
    access(0, 1, 32'h32, 32'h1234BEEF, 2'b01, 0, last_read,    0, 3);
    access(1, 0, 32'h30, 32'h0,        2'b10, 0, 32'hBEEF7FFF, 0, 3);
    // Misaligned accesses and protocol error leave memory untouched
    access(1, 0, 32'h13, 32'h0,        2'b10, 0, 32'h0,        1, 1);
    access(0, 1, 32'h12, 32'hFFFFFFFF, 2'b10, 0, 32'h0,        1, 1);
    access(1, 0, 32'h31, 32'h0,        2'b01, 0, 32'h0,        1, 1);
    access(1, 0, 32'h10, 32'h0,        2'b11, 0, 32'hDEADBEEF, 0, 3);
    access(1, 1, 32'h10, 32'h0,        2'b10, 0, 32'h0,        1, -1);
    access(1, 0, 32'h10, 32'h0,        2'b10, 0, 32'hDEADBEEF, 0, 3);
    access(1, 0, 32'h30, 32'h0,        2'b10, 0, 32'hBEEF7FFF, 0, 3);
`ifdef DMEM_ERRCNT_EN
    chk("errcount", 32'(errcount), 32'(mis_events));
`endif

    // Reset during BUSY aborts a pending store
    access(0, 1, 32'h40, 32'h12345678, 2'b10, 0, last_read, 0, 3);
    @(negedge clk);
    memwrite = 1'b1; addr = 32'h40; writedata = 32'h00000055; size = 2'b00;
    @(posedge clk);
    #1;
    memwrite = 1'b0;
    @(negedge clk);
    chk("busy_stall", 32'(stall), 32'h1);
    rstn = 1'b0;
    #1;
    chk("midrst_stall", 32'(stall), 32'h0);
    chk("midrst_done", 32'(done), 32'h0);
    chk("midrst_memreadout", memreadout, 32'h0);
    chk("midrst_misalign", 32'(misalign), 32'h0);
    repeat (2) @(negedge clk);
    rstn = 1'b1;
    last_read = 32'h0;
    @(negedge clk);
    access(1, 0, 32'h40, 32'h0, 2'b10, 0, 32'h12345678, 0, 3);

    // Address wrap-around modulo 1 KiB
    access(0, 1, 32'h404, 32'hCAFEF00D, 2'b10, 0, last_read,    0, 3);
    access(1, 0, 32'h004, 32'h0,        2'b10, 0, 32'hCAFEF00D, 0, 3);

    repeat (3) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
